// File: rtl/m_pipe_ctrl_if.sv
// m_pipe_ctrl_if -- signal bundle between the pipeline datapath and the
// pipeline controller.
//   master : the datapath. It drives the ID operand fields, the per-stage
//            destination/write/load flags and branch resolution. It receives
//            stall/bubble/flush and the operand forwarding selects.
//   slave  : the controller (m_pipe_ctrl). It has the reverse directions.
interface m_pipe_ctrl_if;
  logic [4:0] w_id_rs;
  logic [4:0] w_id_rt;
  logic       w_id_use_rt;
  logic       w_id_halt;
  logic [4:0] w_idex_rd2;
  logic [4:0] w_exme_rd2;
  logic [4:0] w_mewb_rd2;
  logic       w_idex_w;
  logic       w_exme_w;
  logic       w_mewb_w;
  logic       w_idex_ld;
  logic       w_exme_ld;
  logic       w_ex_taken;
  logic       w_stall;
  logic       w_bubble;
  logic       w_flush;
  logic [1:0] w_fwd_rs;
  logic [1:0] w_fwd_rt;

  modport master (
    output w_id_rs, w_id_rt, w_id_use_rt, w_id_halt,
           w_idex_rd2, w_exme_rd2, w_mewb_rd2,
           w_idex_w, w_exme_w, w_mewb_w,
           w_idex_ld, w_exme_ld, w_ex_taken,
    input  w_stall, w_bubble, w_flush, w_fwd_rs, w_fwd_rt
  );

  modport slave (
    input  w_id_rs, w_id_rt, w_id_use_rt, w_id_halt,
           w_idex_rd2, w_exme_rd2, w_mewb_rd2,
           w_idex_w, w_exme_w, w_mewb_w,
           w_idex_ld, w_exme_ld, w_ex_taken,
    output w_stall, w_bubble, w_flush, w_fwd_rs, w_fwd_rt
  );
endinterface

// File: rtl/m_pipe_ctrl.sv
// m_pipe_ctrl -- hazard, forwarding and halt controller for a 5-stage core.
// It detects load-use hazards and stalls for them. It flushes the IF/ID
// stage on a taken branch and selects the forwarding paths for both ID
// operands. A HALT instruction drains the pipeline for DRAIN_CYC cycles
// before the core parks in HALTED.
// Ports:
//   w_clk   : rising-edge clock
//   w_rst_n : asynchronous active-low reset
//   ctrl    : m_pipe_ctrl_if.slave (stage fields in; stall/bubble/flush/fwd out)
//   r_halt  : core halted (registered)
//   r_cyc   : active-cycle counter, 32 bits, wraps
//   r_stl   : load-use stall counter, STL_W bits, saturating
// DRAIN_CYC must be in the range 1..7 because it is loaded into a 3-bit counter.
module m_pipe_ctrl #(
  parameter int DRAIN_CYC = 3,
  parameter int STL_W     = 16
) (
  input  logic             w_clk,
  input  logic             w_rst_n,
  m_pipe_ctrl_if.slave     ctrl,
  output logic             r_halt,
  output logic [31:0]      r_cyc,
  output logic [STL_W-1:0] r_stl
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t     state_reg, state_next;
  logic [2:0] r_dcnt, dcnt_next;
  logic       halt_next;
  logic       stall_c, bubble_c, flush_c;
  logic       hz;

  // A load in a later stage whose destination is a source of ID. Register 0
  // is excluded because writes to it are discarded.
  function automatic logic load_hz(input logic w, input logic ld, input logic [4:0] rd,
                                   input logic [4:0] rs, input logic [4:0] rt,
                                   input logic use_rt);
    return w & ld & (rd != 5'd0) & ((rd == rs) | (use_rt & (rd == rt)));
  endfunction

  // ExMe takes priority because it holds the younger result. A load in ExMe
  // has no data yet and cannot be forwarded from there.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic exme_w, input logic exme_ld,
                                         input logic [4:0] exme_rd,
                                         input logic mewb_w, input logic [4:0] mewb_rd);
    if (exme_w && !exme_ld && exme_rd != 5'd0 && exme_rd == src)
      return 2'b01;
    else if (mewb_w && mewb_rd != 5'd0 && mewb_rd == src)
      return 2'b10;
    else
      return 2'b00;
  endfunction

  assign hz = load_hz(ctrl.w_idex_w, ctrl.w_idex_ld, ctrl.w_idex_rd2,
                      ctrl.w_id_rs, ctrl.w_id_rt, ctrl.w_id_use_rt)
            | load_hz(ctrl.w_exme_w, ctrl.w_exme_ld, ctrl.w_exme_rd2,
                      ctrl.w_id_rs, ctrl.w_id_rt, ctrl.w_id_use_rt);

  // Forwarding stays live in every state.
  assign ctrl.w_fwd_rs = fwd_sel(ctrl.w_id_rs, ctrl.w_exme_w, ctrl.w_exme_ld,
                                 ctrl.w_exme_rd2, ctrl.w_mewb_w, ctrl.w_mewb_rd2);
  assign ctrl.w_fwd_rt = ctrl.w_id_use_rt
                       ? fwd_sel(ctrl.w_id_rt, ctrl.w_exme_w, ctrl.w_exme_ld,
                                 ctrl.w_exme_rd2, ctrl.w_mewb_w, ctrl.w_mewb_rd2)
                       : 2'b00;

  // The pipeline controls are forced low while reset is held.
  assign ctrl.w_stall  = stall_c  & w_rst_n;
  assign ctrl.w_bubble = bubble_c & w_rst_n;
  assign ctrl.w_flush  = flush_c  & w_rst_n;

  always_comb begin
    state_next = state_reg;
    dcnt_next  = r_dcnt;
    halt_next  = r_halt;
    stall_c    = 1'b0;
    bubble_c   = 1'b0;
    flush_c    = 1'b0;
    case (state_reg)
      RUN: begin
        // A taken branch squashes everything younger, including a pending
        // hazard and any HALT still sitting in ID.
        if (ctrl.w_ex_taken) begin
          flush_c  = 1'b1;
          bubble_c = 1'b1;
        end else if (hz) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
        end else if (ctrl.w_id_halt) begin
          state_next = DRAIN;
          dcnt_next  = 3'(DRAIN_CYC - 1);
        end
      end
      DRAIN: begin
        stall_c  = 1'b1;
        bubble_c = 1'b1;
        if (r_dcnt == 3'd0) begin
          state_next = HALTED;
          halt_next  = 1'b1;
        end else begin
          dcnt_next = r_dcnt - 3'd1;
        end
      end
      HALTED: begin
        stall_c  = 1'b1;
        bubble_c = 1'b1;
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_reg <= RUN;
      r_dcnt    <= 3'd0;
      r_halt    <= 1'b0;
      r_cyc     <= 32'd0;
      r_stl     <= '0;
    end else begin
      state_reg <= state_next;
      r_dcnt    <= dcnt_next;
      r_halt    <= halt_next;
      if (state_reg != HALTED)
        r_cyc <= r_cyc + 32'd1;
      // Only load-use stalls count. DRAIN/HALTED stalls are excluded.
      if (state_reg == RUN && stall_c && !flush_c && r_stl != {STL_W{1'b1}})
        r_stl <= r_stl + {{(STL_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_m_pipe_ctrl.sv
module tb_m_pipe_ctrl;
  localparam int DRAIN_CYC = 3;
  localparam int STL_W     = 16;
  localparam int NV        = 15;

  logic             w_clk = 1'b0;
  logic             w_rst_n = 1'b0;
  logic             r_halt;
  logic [31:0]      r_cyc;
  logic [STL_W-1:0] r_stl;

  always #5 w_clk = ~w_clk;

  m_pipe_ctrl_if pif ();

  m_pipe_ctrl #(.DRAIN_CYC(DRAIN_CYC), .STL_W(STL_W)) dut (
    .w_clk   (w_clk),
    .w_rst_n (w_rst_n),
    .ctrl    (pif.slave),
    .r_halt  (r_halt),
    .r_cyc   (r_cyc),
    .r_stl   (r_stl)
  );

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rt;
    logic       halt;
    logic [4:0] idex_rd;
    logic       idex_w;
    logic       idex_ld;
    logic [4:0] exme_rd;
    logic       exme_w;
    logic       exme_ld;
    logic [4:0] mewb_rd;
    logic       mewb_w;
    logic       taken;
    logic       stall;
    logic       bubble;
    logic       flush;
    logic [1:0] fwd_rs;
    logic [1:0] fwd_rt;
  } vec_t;

  typedef struct {
    logic       stall;
    logic       bubble;
    logic       flush;
    logic [1:0] fwd_rs;
    logic [1:0] fwd_rt;
  } exp_t;

  vec_t vecs [NV];
  exp_t sb_q [$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   exp_stl = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic clear_in();
    pif.w_id_rs     = 5'd0;
    pif.w_id_rt     = 5'd0;
    pif.w_id_use_rt = 1'b0;
    pif.w_id_halt   = 1'b0;
    pif.w_idex_rd2  = 5'd0;
    pif.w_idex_w    = 1'b0;
    pif.w_idex_ld   = 1'b0;
    pif.w_exme_rd2  = 5'd0;
    pif.w_exme_w    = 1'b0;
    pif.w_exme_ld   = 1'b0;
    pif.w_mewb_rd2  = 5'd0;
    pif.w_mewb_w    = 1'b0;
    pif.w_ex_taken  = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    pif.w_id_rs     = v.rs;
    pif.w_id_rt     = v.rt;
    pif.w_id_use_rt = v.use_rt;
    pif.w_id_halt   = v.halt;
    pif.w_idex_rd2  = v.idex_rd;
    pif.w_idex_w    = v.idex_w;
    pif.w_idex_ld   = v.idex_ld;
    pif.w_exme_rd2  = v.exme_rd;
    pif.w_exme_w    = v.exme_w;
    pif.w_exme_ld   = v.exme_ld;
    pif.w_mewb_rd2  = v.mewb_rd;
    pif.w_mewb_w    = v.mewb_w;
    pif.w_ex_taken  = v.taken;
  endtask

  task automatic push_exp(input logic s, input logic b, input logic f,
                          input logic [1:0] frs, input logic [1:0] frt);
    exp_t e;
    e.stall = s; e.bubble = b; e.flush = f; e.fwd_rs = frs; e.fwd_rt = frt;
    sb_q.push_back(e);
  endtask

  task automatic check_ctrl(input string nm);
    exp_t e;
    #1;
    if (sb_q.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL %s scoreboard empty actual=0 required=1", nm);
    end else begin
      e = sb_q.pop_front();
      chk({nm, "_stall"},  32'(pif.w_stall),  32'(e.stall));
      chk({nm, "_bubble"}, 32'(pif.w_bubble), 32'(e.bubble));
      chk({nm, "_flush"},  32'(pif.w_flush),  32'(e.flush));
      chk({nm, "_fwd_rs"}, 32'(pif.w_fwd_rs), 32'(e.fwd_rs));
      chk({nm, "_fwd_rt"}, 32'(pif.w_fwd_rt), 32'(e.fwd_rt));
      $display("txn %s stall=%b bubble=%b flush=%b fwd_rs=%b fwd_rt=%b halt=%b cyc=%0d stl=%0d",
               nm, pif.w_stall, pif.w_bubble, pif.w_flush, pif.w_fwd_rs, pif.w_fwd_rt,
               r_halt, r_cyc, r_stl);
    end
  endtask

  task automatic step();
    @(negedge w_clk);
  endtask

  // Returns at a falling edge with reset just released and inputs cleared.
  task automatic do_reset();
    @(negedge w_clk);
    clear_in();
    w_rst_n = 1'b0;
    @(negedge w_clk);
    w_rst_n = 1'b1;
  endtask

  initial begin
    // rs rt urt hlt | idex rd w ld | exme rd w ld | mewb rd w | tkn || stall bub flush frs frt
    vecs[0]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    vecs[1]  = '{5'd3, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00};
    vecs[2]  = '{5'd3, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00};
    vecs[3]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    vecs[4]  = '{5'd2, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01};
    vecs[5]  = '{5'd2, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    vecs[6]  = '{5'd4, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00};
    vecs[7]  = '{5'd1, 5'd6, 1'b1, 1'b0, 5'd6, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00};
    vecs[8]  = '{5'd1, 5'd6, 1'b0, 1'b0, 5'd6, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    vecs[9]  = '{5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    vecs[10] = '{5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00};
    vecs[11] = '{5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00};
    vecs[12] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00};
    vecs[13] = '{5'd9, 5'd9, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 2'b10};
    vecs[14] = '{5'd8, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00};

    clear_in();
    // Hazard inputs are active while reset is held; the controls must stay low.
    pif.w_idex_rd2 = 5'd5; pif.w_idex_w = 1'b1; pif.w_idex_ld = 1'b1; pif.w_id_rs = 5'd5;
    #3;
    chk("rst_stall", 32'(pif.w_stall), 32'd0);
    chk("rst_bubble", 32'(pif.w_bubble), 32'd0);
    do_reset();
    chk("rst_halt", 32'(r_halt), 32'd0);
    chk("rst_cyc", r_cyc, 32'd0);
    chk("rst_stl", 32'(r_stl), 32'd0);

    // Table of single-cycle vectors, all in RUN.
    for (int i = 0; i < NV; i++) begin
      apply(vecs[i]);
      push_exp(vecs[i].stall, vecs[i].bubble, vecs[i].flush, vecs[i].fwd_rs, vecs[i].fwd_rt);
      if (vecs[i].stall && !vecs[i].flush) exp_stl++;
      check_ctrl($sformatf("vec%0d", i));
      step();
    end
    clear_in();
    chk("tbl_stl", 32'(r_stl), 32'(exp_stl));
    chk("tbl_cyc", r_cyc, 32'(NV));

    // Load-use: load to r5 in IdEx, then in ExMe, then forwarded from MeWb.
    do_reset();
    pif.w_idex_rd2 = 5'd5; pif.w_idex_w = 1'b1; pif.w_idex_ld = 1'b1; pif.w_id_rs = 5'd5;
    push_exp(1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
    check_ctrl("lu_c0");
    step();
    clear_in();
    pif.w_id_rs = 5'd5; pif.w_exme_rd2 = 5'd5; pif.w_exme_w = 1'b1; pif.w_exme_ld = 1'b1;
    push_exp(1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
    check_ctrl("lu_c1");
    step();
    clear_in();
    pif.w_id_rs = 5'd5; pif.w_mewb_rd2 = 5'd5; pif.w_mewb_w = 1'b1;
    push_exp(1'b0, 1'b0, 1'b0, 2'b10, 2'b00);
    check_ctrl("lu_c2");
    chk("lu_stl", 32'(r_stl), 32'd2);
    step();
    // Taken branch over the same hazard: flush, no stall, r_stl unchanged.
    clear_in();
    pif.w_idex_rd2 = 5'd5; pif.w_idex_w = 1'b1; pif.w_idex_ld = 1'b1; pif.w_id_rs = 5'd5;
    pif.w_ex_taken = 1'b1;
    push_exp(1'b0, 1'b1, 1'b1, 2'b00, 2'b00);
    check_ctrl("br_hz");
    step();
    clear_in();
    chk("br_stl", 32'(r_stl), 32'd2);

    // Halt: DRAIN_CYC drain cycles, then HALTED with r_cyc frozen.
    do_reset();
    pif.w_id_halt = 1'b1;
    push_exp(1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    check_ctrl("hlt_req");
    step();
    clear_in();
    for (int k = 0; k < DRAIN_CYC; k++) begin
      push_exp(1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
      check_ctrl($sformatf("drain%0d", k));
      chk($sformatf("drain%0d_halt", k), 32'(r_halt), 32'd0);
      step();
    end
    chk("hlt_set", 32'(r_halt), 32'd1);
    chk("hlt_cyc", r_cyc, 32'(DRAIN_CYC + 1));
    pif.w_id_rs = 5'd3; pif.w_exme_rd2 = 5'd3; pif.w_exme_w = 1'b1; pif.w_ex_taken = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push_exp(1'b1, 1'b1, 1'b0, 2'b01, 2'b00);
      check_ctrl($sformatf("halted%0d", k));
      step();
    end
    clear_in();
    chk("halted_cyc", r_cyc, 32'(DRAIN_CYC + 1));
    chk("halted_halt", 32'(r_halt), 32'd1);

    // Halt masked by a taken branch, then held off by a hazard.
    do_reset();
    pif.w_id_halt = 1'b1; pif.w_ex_taken = 1'b1;
    push_exp(1'b0, 1'b1, 1'b1, 2'b00, 2'b00);
    check_ctrl("hm_taken");
    step();
    clear_in();
    push_exp(1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    check_ctrl("hm_run");
    step();
    pif.w_id_halt = 1'b1;
    pif.w_idex_rd2 = 5'd5; pif.w_idex_w = 1'b1; pif.w_idex_ld = 1'b1; pif.w_id_rs = 5'd5;
    push_exp(1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
    check_ctrl("hm_hz");
    step();
    clear_in();
    push_exp(1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    check_ctrl("hm_after");
    step();
    step();
    chk("hm_halt", 32'(r_halt), 32'd0);

    // Reset asserted in the second DRAIN cycle.
    do_reset();
    pif.w_id_halt = 1'b1;
    step();
    clear_in();
    push_exp(1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
    check_ctrl("rd_d1");
    step();
    push_exp(1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
    check_ctrl("rd_d2");
    #2;
    w_rst_n = 1'b0;
    #1;
    chk("rd_cyc", r_cyc, 32'd0);
    chk("rd_halt", 32'(r_halt), 32'd0);
    chk("rd_stall", 32'(pif.w_stall), 32'd0);
    chk("rd_bubble", 32'(pif.w_bubble), 32'd0);
    @(negedge w_clk);
    w_rst_n = 1'b1;
    step();
    step();
    chk("rd_cyc2", r_cyc, 32'd2);
    push_exp(1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    check_ctrl("rd_run");
    step();
    step();
    step();
    chk("rd_halt2", 32'(r_halt), 32'd0);
    chk("rd_stall2", 32'(pif.w_stall), 32'd0);
    chk("rd_cyc5", r_cyc, 32'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/m_pipe_ctrl.md
M_PIPE_CTRL -- requirements
Module: m_pipe_ctrl

Interface
REQ-001 Parameter DRAIN_CYC, default 3: cycles spent in DRAIN before HALTED, allowed range 1..7.
REQ-002 Parameter STL_W, default 16: width of the stall counter.
REQ-003 Reset: one clock; reset is asynchronous and active-low.
REQ-004 w_clk  in  1  rising-edge clock.
REQ-005 w_rst_n  in  1  asynchronous active-low reset.
REQ-006 w_id_rs, w_id_rt  in  5 each  source register fields of the instruction in ID.
REQ-007 w_id_use_rt  in  1  rt is a source in ID: R-type, beq, bne, sw.
REQ-008 w_id_halt  in  1  instruction in ID is HALT.
REQ-009 w_idex_rd2, w_exme_rd2, w_mewb_rd2  in  5 each  destination register per stage.
REQ-010 w_idex_w, w_exme_w, w_mewb_w  in  1 each  stage writes the register file.
REQ-011 w_idex_ld, w_exme_ld  in  1 each  stage holds a load.
REQ-012 w_ex_taken  in  1  branch in EX resolved taken.
REQ-013 w_stall  out  1  hold r_pc and the IfId registers.
REQ-014 w_bubble  out  1  load NOP into IdEx: IdEx_w=0, IdEx_we=0.
REQ-015 w_flush  out  1  replace the IfId instruction with NOP.
REQ-016 w_fwd_rs, w_fwd_rt  out  2 each  operand select: 00 regfile, 01 ExMe_rslt, 10 MeWb result.
REQ-017 r_halt  out  1  core halted, registered.
REQ-018 r_cyc  out  32  active-cycle counter, registered.
REQ-019 r_stl  out  STL_W  load-use stall counter, registered.

Function
REQ-020 FSM states: RUN, DRAIN, HALTED; down-counter r_dcnt is 3 bits wide.
REQ-021 Hazard definition: hz = (w_idex_w & w_idex_ld & w_idex_rd2!=0 & (w_idex_rd2==w_id_rs | w_id_use_rt & w_idex_rd2==w_id_rt)), OR the same expression evaluated on the ExMe signals.
REQ-022 RUN with w_ex_taken=1: w_flush=1, w_bubble=1, w_stall=0; hz is ignored and the halt request is ignored.
REQ-023 RUN with w_ex_taken=0 and hz=1: w_stall=1, w_bubble=1, w_flush=0; the stall lasts as many cycles as hz remains true (2 cycles for a load immediately followed by its use).
REQ-024 RUN otherwise: w_stall, w_bubble and w_flush are all 0.
REQ-025 w_fwd_rs selection, checked in priority order:
  - 01 when w_exme_w & !w_exme_ld & w_exme_rd2!=0 & w_exme_rd2==w_id_rs;
  - else 10 when w_mewb_w & w_mewb_rd2!=0 & w_mewb_rd2==w_id_rs;
  - else 00.
REQ-026 w_fwd_rt uses the same rule as REQ-025 with w_id_rt; it is forced to 00 when w_id_use_rt=0.
REQ-027 Forwarding outputs are combinational and remain valid in every state.
REQ-028 Transition RUN->DRAIN at a clock edge where w_id_halt=1, w_ex_taken=0 and hz=0; r_dcnt is loaded with DRAIN_CYC-1 on that edge.
REQ-029 DRAIN outputs: w_stall=1, w_bubble=1, w_flush=0.
REQ-030 DRAIN counting: r_dcnt decrements each edge; when r_dcnt==0 the next edge enters HALTED and sets r_halt=1, giving exactly DRAIN_CYC cycles in DRAIN.
REQ-031 HALTED outputs: w_stall=1, w_bubble=1, w_flush=0, r_halt=1; HALTED is exited only by reset.
REQ-032 r_cyc increments by 1 every edge in RUN or DRAIN, wraps modulo 2^32, and holds in HALTED.
REQ-033 r_stl increments on each edge in RUN where w_stall=1 and w_flush=0, and saturates at all-ones.
REQ-034 r0 is never a hazard source and is never forwarded.

Reset
REQ-035 On w_rst_n=0, immediately and independent of w_clk: state=RUN, r_dcnt=0, r_halt=0, r_cyc=0, r_stl=0.
REQ-036 While w_rst_n=0, w_stall, w_bubble and w_flush are 0.
REQ-037 Assertion of w_rst_n=0 during DRAIN or HALTED aborts the sequence; the first edge after release resumes counting in RUN.

Verification
REQ-038 Load-use: IdEx load with rd2=5, ID reads rs=5 -> w_stall=w_bubble=1 for 2 cycles, r_stl=2, then w_fwd_rs=10.
REQ-039 ALU forward: ExMe addi to r3 and MeWb write to r3, ID rs=3 -> w_fwd_rs=01; with the ExMe write removed -> w_fwd_rs=10; with rs=0 -> w_fwd_rs=00.
REQ-040 Branch over hazard: w_ex_taken=1 and hz=1 together -> w_flush=1, w_stall=0, r_stl unchanged.
REQ-041 Halt: w_id_halt=1 with DRAIN_CYC=3 -> 3 DRAIN cycles with w_stall=1, then r_halt=1; r_cyc freezes at its value on HALTED entry.
REQ-042 Halt masked: w_id_halt=1 with w_ex_taken=1 -> state stays RUN, w_flush=1.
REQ-043 Reset mid-DRAIN: pull w_rst_n low in the 2nd DRAIN cycle -> r_halt=0, r_cyc=0 asynchronously; after release the block runs normally.
